// File: rtl/ifetch_miss_handler_pkg.sv
// Shared L1I miss-handling types: line address split, entry record and index widths.
package ifetch_miss_handler_pkg;
  localparam int THREADS_PER_CORE        = 4;
  localparam int L1I_WAYS                = 4;
  localparam int L1I_SETS                = 64;
  localparam int CACHE_LINE_BYTES        = 64;
  localparam int CACHE_LINE_BITS         = CACHE_LINE_BYTES * 8;
  localparam int ADDR_WIDTH              = 32;
  localparam int SET_IDX_WIDTH           = $clog2(L1I_SETS);
  localparam int CACHE_LINE_INDEX_WIDTH  = ADDR_WIDTH - $clog2(CACHE_LINE_BYTES);
  localparam int TAG_WIDTH               = CACHE_LINE_INDEX_WIDTH - SET_IDX_WIDTH;
  localparam int IMH_IDX_WIDTH           = $clog2(THREADS_PER_CORE);

  typedef logic [CACHE_LINE_INDEX_WIDTH-1:0] cache_line_index_t;
  typedef logic [SET_IDX_WIDTH-1:0]          l1i_set_idx_t;
  typedef logic [TAG_WIDTH-1:0]              l1i_tag_t;
  typedef logic [CACHE_LINE_BITS-1:0]        cache_line_data_t;
  typedef logic [$clog2(L1I_WAYS)-1:0]       l1i_way_idx_t;
  typedef logic [IMH_IDX_WIDTH-1:0]          local_thread_idx_t;

  typedef struct packed {
    logic                        valid;
    logic                        sent;
    cache_line_index_t           addr;
    logic [THREADS_PER_CORE-1:0] waiters;
  } ifetch_miss_entry_t;

  function automatic l1i_set_idx_t line_set(input cache_line_index_t addr);
    return addr[SET_IDX_WIDTH-1:0];
  endfunction

  function automatic l1i_tag_t line_tag(input cache_line_index_t addr);
    return addr[CACHE_LINE_INDEX_WIDTH-1:SET_IDX_WIDTH];
  endfunction

  function automatic logic [THREADS_PER_CORE-1:0] thread_onehot(input local_thread_idx_t t);
    return {{(THREADS_PER_CORE-1){1'b0}}, 1'b1} << t;
  endfunction

  function automatic logic [L1I_WAYS-1:0] way_onehot(input l1i_way_idx_t w);
    return {{(L1I_WAYS-1){1'b0}}, 1'b1} << w;
  endfunction
endpackage

// File: rtl/ifetch_miss_handler_chk.sv
// Protocol checks for the miss handler: no double miss per thread, fills only for sent entries.
module ifetch_miss_handler_chk
  import ifetch_miss_handler_pkg::*;
#(
  parameter int NUM_ENTRIES = THREADS_PER_CORE,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input logic                   clk,
  input logic                   reset,
  input logic [NUM_ENTRIES-1:0] valid_vec,
  input logic [NUM_ENTRIES-1:0] sent_vec,
  input logic                   f1_valid,
  input logic [IDX_WIDTH-1:0]   f1_idx,
  input logic                   miss,
  input local_thread_idx_t      miss_thread,
  input logic                   resp_valid,
  input logic [IDX_WIDTH-1:0]   resp_idx
);
  // An entry being freed this cycle may be reallocated by its own thread.
  a_no_double_miss: assert property (@(posedge clk) disable iff (reset)
    !(miss && valid_vec[miss_thread] &&
      !(f1_valid && (f1_idx == IDX_WIDTH'(miss_thread)))));

  a_resp_targets_sent: assert property (@(posedge clk) disable iff (reset)
    resp_valid |-> (valid_vec[resp_idx] && sent_vec[resp_idx]));
endmodule

// File: rtl/ifetch_miss_handler_rr_arbiter.sv
// Round-robin arbiter that locks onto a stalled grant until it is accepted.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   request,
  input  logic                 advance,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_idx
);
  logic [IDX_WIDTH-1:0] ptr_r;
  logic [IDX_WIDTH-1:0] hold_idx_r;
  logic                 hold_r;
  logic [IDX_WIDTH-1:0] pick_idx_s;
  logic                 pick_valid_s;

  // Pick the first requester at or after the pointer; descending scan lets the nearest win.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pick_valid_s = request[(int'(ptr_r) + k) % NUM_REQ] ? 1'b1 : pick_valid_s;
      pick_idx_s   = request[(int'(ptr_r) + k) % NUM_REQ] ?
                     IDX_WIDTH'((int'(ptr_r) + k) % NUM_REQ) : pick_idx_s;
    end
    grant_valid = hold_r | pick_valid_s;
    grant_idx   = hold_r ? hold_idx_r : pick_idx_s;
  end

  // Pointer advance on acceptance; hold a stalled grant so the request stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r      <= '0;
      hold_r     <= 1'b0;
      hold_idx_r <= '0;
    end else if (grant_valid && advance) begin
      ptr_r  <= (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);
      hold_r <= 1'b0;
    end else if (grant_valid) begin
      hold_r     <= 1'b1;
      hold_idx_r <= grant_idx;
    end else begin
      hold_r <= 1'b0;
    end
  end
endmodule

// File: rtl/ifetch_miss_handler.sv
// L1I miss handler: per-thread pending table, L2 request issue, 3-stage fill (LRU, tag+wake, data).
// Optional IFETCH_MISS_PERF_EN adds merge-pulse and pending-count outputs.
module ifetch_miss_handler
  import ifetch_miss_handler_pkg::*;
#(
  parameter int NUM_ENTRIES = THREADS_PER_CORE,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ifd_cache_miss,
  input  cache_line_index_t           ifd_cache_miss_paddr,
  input  local_thread_idx_t           ifd_cache_miss_thread_idx,
  output logic                        imh_l2_req_valid,
  input  logic                        l2_req_ready,
  output cache_line_index_t           imh_l2_req_addr,
  output logic [IDX_WIDTH-1:0]        imh_l2_req_idx,
  input  logic                        l2_resp_valid,
  input  logic [IDX_WIDTH-1:0]        l2_resp_idx,
  input  cache_line_data_t            l2_resp_data,
  output logic                        imh_lru_fill_en,
  output l1i_set_idx_t                imh_lru_fill_set,
  input  l1i_way_idx_t                ift_fill_lru,
  output logic [L1I_WAYS-1:0]         l2i_itag_update_en,
  output l1i_set_idx_t                l2i_itag_update_set,
  output l1i_tag_t                    l2i_itag_update_tag,
  output logic                        l2i_idata_update_en,
  output l1i_way_idx_t                l2i_idata_update_way,
  output l1i_set_idx_t                l2i_idata_update_set,
  output cache_line_data_t            l2i_idata_update_data,
  output logic [THREADS_PER_CORE-1:0] l2i_icache_wake_bitmap
`ifdef IFETCH_MISS_PERF_EN
  ,
  output logic                               imh_perf_miss_merged,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   imh_perf_pending_count
`endif
);
  ifetch_miss_entry_t          entries_r [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]      valid_vec_s, sent_vec_s, pending_vec_s, match_vec_s;
  logic                        match_any_s;
  logic [IDX_WIDTH-1:0]        match_idx_s;
  logic [THREADS_PER_CORE-1:0] miss_onehot_s;
  logic                        grant_valid_s, req_fire_s, f1_late_s;
  logic [IDX_WIDTH-1:0]        grant_idx_s;

  logic                        f1_valid_r;
  logic [IDX_WIDTH-1:0]        f1_idx_r;
  l1i_set_idx_t                f1_set_r;
  l1i_tag_t                    f1_tag_r;
  cache_line_data_t            f1_data_r;
  logic                        idata_en_r;
  l1i_way_idx_t                idata_way_r;
  l1i_set_idx_t                idata_set_r;
  cache_line_data_t            idata_data_r;

  // Entry status vectors and address match against the incoming miss.
  always_comb begin
    valid_vec_s   = '0;
    sent_vec_s    = '0;
    pending_vec_s = '0;
    match_vec_s   = '0;
    match_idx_s   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec_s[i]   = entries_r[i].valid;
      sent_vec_s[i]    = entries_r[i].sent;
      pending_vec_s[i] = entries_r[i].valid & ~entries_r[i].sent;
      match_vec_s[i]   = entries_r[i].valid && (entries_r[i].addr == ifd_cache_miss_paddr);
      match_idx_s      = match_vec_s[i] ? IDX_WIDTH'(i) : match_idx_s;
    end
    match_any_s = |match_vec_s;
  end

  assign miss_onehot_s = thread_onehot(ifd_cache_miss_thread_idx);
  assign req_fire_s    = grant_valid_s & l2_req_ready;

  rr_arbiter #(.NUM_REQ(NUM_ENTRIES), .IDX_WIDTH(IDX_WIDTH)) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .request     (pending_vec_s),
    .advance     (l2_req_ready),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  assign imh_l2_req_valid = grant_valid_s;
  assign imh_l2_req_addr  = grant_valid_s ? entries_r[grant_idx_s].addr : '0;
  assign imh_l2_req_idx   = grant_valid_s ? grant_idx_s : '0;

  // F0 is the response cycle itself, so the victim lookup follows the L2 response directly.
  assign imh_lru_fill_en  = l2_resp_valid & ~reset;
  assign imh_lru_fill_set = imh_lru_fill_en ? line_set(entries_r[l2_resp_idx].addr) : '0;

  // F1: the victim way arrives now; a miss to the filling line this cycle joins the wake.
  assign f1_late_s              = ifd_cache_miss && (ifd_cache_miss_paddr == {f1_tag_r, f1_set_r});
  assign l2i_itag_update_en     = f1_valid_r ? way_onehot(ift_fill_lru) : '0;
  assign l2i_itag_update_set    = f1_valid_r ? f1_set_r : '0;
  assign l2i_itag_update_tag    = f1_valid_r ? f1_tag_r : '0;
  assign l2i_icache_wake_bitmap = f1_valid_r ?
         (entries_r[f1_idx_r].waiters | (f1_late_s ? miss_onehot_s : '0)) : '0;

  assign l2i_idata_update_en   = idata_en_r;
  assign l2i_idata_update_way  = idata_way_r;
  assign l2i_idata_update_set  = idata_set_r;
  assign l2i_idata_update_data = idata_data_r;

  // Fill pipeline registers: each stage carries its own payload so responses can stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f1_valid_r   <= 1'b0;
      f1_idx_r     <= '0;
      f1_set_r     <= '0;
      f1_tag_r     <= '0;
      f1_data_r    <= '0;
      idata_en_r   <= 1'b0;
      idata_way_r  <= '0;
      idata_set_r  <= '0;
      idata_data_r <= '0;
    end else begin
      f1_valid_r   <= l2_resp_valid;
      f1_idx_r     <= l2_resp_idx;
      f1_set_r     <= line_set(entries_r[l2_resp_idx].addr);
      f1_tag_r     <= line_tag(entries_r[l2_resp_idx].addr);
      f1_data_r    <= l2_resp_data;
      idata_en_r   <= f1_valid_r;
      idata_way_r  <= f1_valid_r ? ift_fill_lru : '0;
      idata_set_r  <= f1_valid_r ? f1_set_r : '0;
      idata_data_r <= f1_valid_r ? f1_data_r : '0;
    end
  end

  // Pending table: grant marks sent, F1 frees, merge ORs waiters; a later allocate overrides the free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (req_fire_s) begin
        entries_r[grant_idx_s].sent <= 1'b1;
      end
      if (f1_valid_r) begin
        entries_r[f1_idx_r].valid <= 1'b0;
      end
      if (ifd_cache_miss && match_any_s) begin
        entries_r[match_idx_s].waiters <= entries_r[match_idx_s].waiters | miss_onehot_s;
      end else if (ifd_cache_miss) begin
        entries_r[ifd_cache_miss_thread_idx] <= '{valid: 1'b1, sent: 1'b0,
                                                  addr: ifd_cache_miss_paddr,
                                                  waiters: miss_onehot_s};
      end
    end
  end

`ifdef IFETCH_MISS_PERF_EN
  logic                              perf_merged_r;
  logic [$clog2(NUM_ENTRIES+1)-1:0]  perf_count_r;

  // Performance counters: merge pulse and registered occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_merged_r <= 1'b0;
      perf_count_r  <= '0;
    end else begin
      perf_merged_r <= ifd_cache_miss & match_any_s;
      perf_count_r  <= ($clog2(NUM_ENTRIES+1))'($countones(valid_vec_s));
    end
  end

  assign imh_perf_miss_merged   = perf_merged_r;
  assign imh_perf_pending_count = perf_count_r;
`endif

  ifetch_miss_handler_chk #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_WIDTH(IDX_WIDTH)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .valid_vec   (valid_vec_s),
    .sent_vec    (sent_vec_s),
    .f1_valid    (f1_valid_r),
    .f1_idx      (f1_idx_r),
    .miss        (ifd_cache_miss),
    .miss_thread (ifd_cache_miss_thread_idx),
    .resp_valid  (l2_resp_valid),
    .resp_idx    (l2_resp_idx)
  );
endmodule

// File: tb/tb_ifetch_miss_handler.sv
// Randomized bench for ifetch_miss_handler with a line-level reference model of misses and fills.
module tb_ifetch_miss_handler;
  import ifetch_miss_handler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ifd_cache_miss;
  cache_line_index_t ifd_cache_miss_paddr;
  local_thread_idx_t ifd_cache_miss_thread_idx;
  logic imh_l2_req_valid, l2_req_ready;
  cache_line_index_t imh_l2_req_addr;
  logic [1:0] imh_l2_req_idx;
  logic l2_resp_valid;
  logic [1:0] l2_resp_idx;
  cache_line_data_t l2_resp_data;
  logic imh_lru_fill_en;
  l1i_set_idx_t imh_lru_fill_set;
  l1i_way_idx_t ift_fill_lru;
  logic [3:0] l2i_itag_update_en;
  l1i_set_idx_t l2i_itag_update_set;
  l1i_tag_t l2i_itag_update_tag;
  logic l2i_idata_update_en;
  l1i_way_idx_t l2i_idata_update_way;
  l1i_set_idx_t l2i_idata_update_set;
  cache_line_data_t l2i_idata_update_data;
  logic [3:0] l2i_icache_wake_bitmap;

  always #5 clk = ~clk;

  ifetch_miss_handler dut (
    .clk(clk), .reset(reset),
    .ifd_cache_miss(ifd_cache_miss), .ifd_cache_miss_paddr(ifd_cache_miss_paddr),
    .ifd_cache_miss_thread_idx(ifd_cache_miss_thread_idx),
    .imh_l2_req_valid(imh_l2_req_valid), .l2_req_ready(l2_req_ready),
    .imh_l2_req_addr(imh_l2_req_addr), .imh_l2_req_idx(imh_l2_req_idx),
    .l2_resp_valid(l2_resp_valid), .l2_resp_idx(l2_resp_idx), .l2_resp_data(l2_resp_data),
    .imh_lru_fill_en(imh_lru_fill_en), .imh_lru_fill_set(imh_lru_fill_set),
    .ift_fill_lru(ift_fill_lru),
    .l2i_itag_update_en(l2i_itag_update_en), .l2i_itag_update_set(l2i_itag_update_set),
    .l2i_itag_update_tag(l2i_itag_update_tag),
    .l2i_idata_update_en(l2i_idata_update_en), .l2i_idata_update_way(l2i_idata_update_way),
    .l2i_idata_update_set(l2i_idata_update_set), .l2i_idata_update_data(l2i_idata_update_data),
    .l2i_icache_wake_bitmap(l2i_icache_wake_bitmap)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending lines per thread slot, round-robin state and fill stages.
  bit m_valid[4], m_sent[4], m_inflight[4];
  cache_line_index_t m_addr[4];
  logic [3:0] m_wait[4];
  logic [3:0] blocked;
  int rr_ptr;
  bit held;
  int held_idx;
  bit e1_v, e2_v;
  int e1_idx;
  cache_line_index_t e1_addr;
  cache_line_data_t e1_data, e2_data;
  int e2_way;
  cache_line_index_t e2_addr;
  int dut_grants[$];
  cache_line_index_t pool[4];

  task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cache_line_data_t rand_line();
    cache_line_data_t d;
    for (int i = 0; i < CACHE_LINE_BITS / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic init_model();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_sent[i] = 0; m_inflight[i] = 0; m_addr[i] = '0; m_wait[i] = '0;
    end
    blocked = '0; rr_ptr = 0; held = 0; held_idx = 0; e1_v = 0; e2_v = 0;
  endtask

  task automatic do_cycle(input bit miss, input cache_line_index_t addr, input int thr,
                          input bit ready, input bit resp, input int ridx, input int lru,
                          input cache_line_data_t data);
    bit exp_req;
    int exp_idx;
    int mj;
    logic [3:0] exp_wake;
    logic [3:0] thr_oh;
    @(negedge clk);
    ifd_cache_miss = miss; ifd_cache_miss_paddr = addr;
    ifd_cache_miss_thread_idx = local_thread_idx_t'(thr);
    l2_req_ready = ready; l2_resp_valid = resp; l2_resp_idx = 2'(ridx);
    l2_resp_data = data; ift_fill_lru = l1i_way_idx_t'(lru);
    #1;
    thr_oh = 4'b0001 << thr;
    exp_req = 0; exp_idx = 0;
    if (held) begin
      exp_req = 1; exp_idx = held_idx;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (rr_ptr + k) % 4;
        if (!exp_req && m_valid[c] && !m_sent[c]) begin exp_req = 1; exp_idx = c; end
      end
    end
    check_value("req_valid", imh_l2_req_valid, exp_req);
    if (exp_req) begin
      check_value("req_idx", imh_l2_req_idx, exp_idx);
      check_value("req_addr", imh_l2_req_addr, m_addr[exp_idx]);
    end else begin
      check_value("req_addr_idle", imh_l2_req_addr, 0);
    end
    if (imh_l2_req_valid && ready) dut_grants.push_back(int'(imh_l2_req_idx));
    check_value("lru_en", imh_lru_fill_en, resp);
    if (resp) check_value("lru_set", imh_lru_fill_set, m_addr[ridx] % L1I_SETS);
    check_value("itag_en", l2i_itag_update_en, e1_v ? (4'b0001 << lru) : 4'b0000);
    if (e1_v) begin
      check_value("itag_set", l2i_itag_update_set, e1_addr % L1I_SETS);
      check_value("itag_tag", l2i_itag_update_tag, e1_addr / L1I_SETS);
    end
    exp_wake = e1_v ? (m_wait[e1_idx] | ((miss && addr == e1_addr) ? thr_oh : 4'b0000)) : 4'b0000;
    check_value("wake", l2i_icache_wake_bitmap, exp_wake);
    check_value("idata_en", l2i_idata_update_en, e2_v);
    if (e2_v) begin
      check_value("idata_way", l2i_idata_update_way, e2_way);
      check_value("idata_set", l2i_idata_update_set, e2_addr % L1I_SETS);
      check_value("idata_data", l2i_idata_update_data, e2_data);
    end
    // advance the model to the next clock edge
    mj = -1;
    for (int j = 0; j < 4; j++) if (m_valid[j] && m_addr[j] == addr) mj = j;
    if (exp_req && ready) begin
      m_sent[exp_idx] = 1; rr_ptr = (exp_idx + 1) % 4; held = 0;
    end else if (exp_req) begin
      held = 1; held_idx = exp_idx;
    end
    if (e1_v) begin m_valid[e1_idx] = 0; m_inflight[e1_idx] = 0; end
    e2_v = e1_v; e2_way = lru; e2_addr = e1_addr; e2_data = e1_data;
    e1_v = resp; e1_idx = ridx; e1_addr = m_addr[ridx]; e1_data = data;
    if (resp) m_inflight[ridx] = 1;
    if (miss) begin
      blocked[thr] = 1'b1;
      if (mj >= 0) m_wait[mj] = m_wait[mj] | thr_oh;
      else begin
        m_valid[thr] = 1; m_sent[thr] = 0; m_addr[thr] = addr; m_wait[thr] = thr_oh;
      end
    end
    blocked = blocked & ~exp_wake;
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) do_cycle(0, '0, 0, ready, 0, 0, $urandom_range(0, 3), '0);
  endtask

  task automatic rand_cycle();
    int thr, cand[$], ridx;
    bit miss, resp;
    thr = $urandom_range(0, 3);
    miss = !blocked[thr] && ($urandom_range(0, 2) == 0);
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_sent[i] && !m_inflight[i]) cand.push_back(i);
    resp = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
    ridx = resp ? cand[$urandom_range(0, cand.size() - 1)] : 0;
    do_cycle(miss, pool[$urandom_range(0, 3)], thr, $urandom_range(0, 9) < 7,
             resp, ridx, $urandom_range(0, 3), rand_line());
  endtask

  initial begin
    cache_line_data_t d;
    int n0;
    init_model();
    reset = 1'b1; ifd_cache_miss = 0; ifd_cache_miss_paddr = '0; ifd_cache_miss_thread_idx = '0;
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_idx = '0; l2_resp_data = '0; ift_fill_lru = '0;
    repeat (2) @(negedge clk);
    #1;
    check_value("rst_req", imh_l2_req_valid, 0);
    check_value("rst_itag", l2i_itag_update_en, 0);
    check_value("rst_idata", l2i_idata_update_en, 0);
    check_value("rst_wake", l2i_icache_wake_bitmap, 0);
    check_value("rst_lru", imh_lru_fill_en, 0);
    reset = 1'b0;

    // single miss, thread 1
    do_cycle(1, 26'h0123456, 1, 1, 0, 0, 0, '0);
    check_value("single_req_pending", imh_l2_req_valid, 0);
    do_cycle(0, '0, 0, 1, 0, 0, 0, '0);
    check_value("single_req_addr", imh_l2_req_addr, 26'h0123456);
    check_value("single_req_idx", imh_l2_req_idx, 1);
    idle(4, 1);
    d = rand_line();
    do_cycle(0, '0, 0, 1, 1, 1, 0, d);
    do_cycle(0, '0, 0, 1, 0, 0, 2, '0);
    check_value("single_itag", l2i_itag_update_en, 4'b0100);
    check_value("single_wake", l2i_icache_wake_bitmap, 4'b0010);
    do_cycle(0, '0, 0, 1, 0, 0, 0, '0);
    check_value("single_data", l2i_idata_update_data, d);
    check_value("single_way", l2i_idata_update_way, 2);

    // merge: threads 0 and 3 on the same line
    n0 = dut_grants.size();
    do_cycle(1, 26'h40, 0, 0, 0, 0, 0, '0);
    do_cycle(0, '0, 0, 0, 0, 0, 0, '0);
    do_cycle(1, 26'h40, 3, 1, 0, 0, 0, '0);
    idle(3, 1);
    check_value("merge_one_req", dut_grants.size() - n0, 1);
    do_cycle(0, '0, 0, 1, 1, 0, 0, rand_line());
    do_cycle(0, '0, 0, 1, 0, 0, 1, '0);
    check_value("merge_wake", l2i_icache_wake_bitmap, 4'b1001);
    idle(2, 1);

    // late merge during F0
    do_cycle(1, 26'h80, 1, 1, 0, 0, 0, '0);
    idle(3, 1);
    do_cycle(1, 26'h80, 2, 1, 1, 1, 0, rand_line());
    do_cycle(0, '0, 0, 1, 0, 0, 3, '0);
    check_value("late_wake", l2i_icache_wake_bitmap, 4'b0110);
    do_cycle(0, '0, 0, 1, 0, 0, 0, '0);
    check_value("late_no_entry", imh_l2_req_valid, 0);

    // backpressure: four misses, ready low, then drained in round-robin order
    n0 = dut_grants.size();
    for (int t = 0; t < 4; t++) do_cycle(1, 26'h100 + 26'(t), t, 0, 0, 0, 0, '0);
    idle(6, 0);
    idle(5, 1);
    check_value("bp_count", dut_grants.size() - n0, 4);
    for (int k = 0; k < 4; k++) check_value("bp_order", dut_grants[n0 + k], k);

    // back-to-back fills
    for (int k = 0; k < 4; k++) do_cycle(0, '0, 0, 1, 1, k, k, rand_line());
    idle(3, 1);

    // reset while a fill sits in F1
    do_cycle(1, 26'h200, 0, 1, 0, 0, 0, '0);
    idle(2, 1);
    do_cycle(0, '0, 0, 1, 1, 0, 0, rand_line());
    @(negedge clk);
    ifd_cache_miss = 0; l2_resp_valid = 0; reset = 1'b1;
    #1;
    check_value("rst_f1_itag", l2i_itag_update_en, 0);
    check_value("rst_f1_wake", l2i_icache_wake_bitmap, 0);
    check_value("rst_f1_req", imh_l2_req_valid, 0);
    @(negedge clk);
    #1;
    check_value("rst_f2_idata", l2i_idata_update_en, 0);
    reset = 1'b0;
    init_model();
    do_cycle(1, 26'h200, 2, 1, 0, 0, 0, '0);
    do_cycle(0, '0, 0, 1, 0, 0, 0, '0);
    check_value("post_rst_idx", imh_l2_req_idx, 2);
    idle(2, 1);

    // randomized traffic with a small address pool to provoke merges
    for (int phase = 0; phase < 4; phase++) begin
      pool[0] = cache_line_index_t'($urandom);
      pool[1] = pool[0] ^ cache_line_index_t'(L1I_SETS);
      pool[2] = cache_line_index_t'($urandom);
      pool[3] = cache_line_index_t'($urandom);
      for (int i = 0; i < 400; i++) rand_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
